// File: rtl/irq_nest_controller.sv
// irq_nest_controller
// Multi-channel, edge-triggered interrupt controller with a software mask,
// fixed priority (lowest index wins) and a return-address stack. A channel
// with a lower index than the one in service may pre-empt it.
//
// Handshake: int_req is a registered level. The control unit takes an
// interrupt by pulsing int_ack while int_req is high, with ret_addr_in valid
// in that same cycle. The controller then answers with a one-cycle vec_valid
// pulse carrying vec_addr. rti pops the stack, and ret_valid pulses for one
// cycle with ret_addr_out. vec_addr and ret_addr_out hold their value
// between pulses.
module irq_nest_controller #(
    parameter int                    NUM_IRQ    = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 16'h0010
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IRQ-1:0]           irq,
    input  logic                         int_enable,
    input  logic                         mask_we,
    input  logic [NUM_IRQ-1:0]           mask_wdata,
    output logic                         int_req,
    input  logic                         int_ack,
    input  logic [ADDR_WIDTH-1:0]        ret_addr_in,
    output logic                         vec_valid,
    output logic [ADDR_WIDTH-1:0]        vec_addr,
    input  logic                         rti,
    output logic                         ret_valid,
    output logic [ADDR_WIDTH-1:0]        ret_addr_out,
    output logic [NUM_IRQ-1:0]           pending,
    output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
    output logic                         stack_err
);

    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VECTOR = 2'd1,
        S_RETURN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_IRQ-1:0]    irq_d_q;
    logic [NUM_IRQ-1:0]    pending_q, pending_d;
    logic [NUM_IRQ-1:0]    mask_q;
    logic [DW-1:0]         depth_q;
    logic                  int_req_q, int_req_d;
    logic [ADDR_WIDTH-1:0] vec_addr_q;
    logic [ADDR_WIDTH-1:0] ret_addr_q;
    logic                  stack_err_q;
    logic [IDW-1:0]        stack_id_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] stack_addr_q [DEPTH];

    logic [NUM_IRQ-1:0]    rise;
    logic [NUM_IRQ-1:0]    below_top;
    logic [NUM_IRQ-1:0]    cand;
    logic [NUM_IRQ-1:0]    win_oh;
    logic [IDW-1:0]        win;
    logic                  cand_any;
    logic [IDW-1:0]        top_id;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic                  accept;
    logic                  pop;
    logic                  err_set;

    assign rise = irq & ~irq_d_q;
    assign cand = pending_q & ~mask_q & below_top;

    // Read the top-of-stack entry (channel id and saved address).
    always_comb begin
        top_id   = '0;
        pop_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_id   = stack_id_q[i];
                pop_addr = stack_addr_q[i];
            end
        end
    end

    // While nested, only channels with a lower index than the one in service may pre-empt it.
    always_comb begin
        below_top = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            below_top[k] = (depth_q == '0) || (IDW'(k) < top_id);
        end
    end

    // Priority pick: the lowest set index of cand wins.
    always_comb begin
        win      = '0;
        cand_any = 1'b0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                win      = IDW'(k);
                cand_any = 1'b1;
            end
        end
    end

    // FSM next state plus the push/pop/error decisions. An ack is taken only
    // while a request is actually standing, so a stale int_req (for example
    // one cycle after a mask write) can never push an empty channel.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (int_ack && int_req_q && cand_any && (depth_q < DW'(DEPTH))) begin
                    accept  = 1'b1;
                    state_d = S_VECTOR;
                    err_set = rti;
                end else if (rti) begin
                    if (depth_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_RETURN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_VECTOR, S_RETURN: begin
                state_d = S_IDLE;
                err_set = int_ack || rti;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending update (set wins over clear) and next request level.
    always_comb begin
        win_oh    = accept ? (NUM_IRQ'(1) << win) : '0;
        pending_d = (pending_q & ~win_oh) | rise;
        int_req_d = int_enable && cand_any && (depth_q < DW'(DEPTH)) &&
                    (state_q == S_IDLE) && !accept && !pop;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers: edge detect, mask, pending, stack and address outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d_q     <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            depth_q     <= '0;
            int_req_q   <= 1'b0;
            vec_addr_q  <= '0;
            ret_addr_q  <= '0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_id_q[i]   <= '0;
                stack_addr_q[i] <= '0;
            end
        end else begin
            irq_d_q   <= irq;
            pending_q <= pending_d;
            int_req_q <= int_req_d;
            if (mask_we) mask_q <= mask_wdata;
            if (accept) begin
                vec_addr_q <= VEC_BASE + ADDR_WIDTH'(win);
                depth_q    <= depth_q + DW'(1);
                for (int i = 0; i < DEPTH; i++) begin
                    if (depth_q == DW'(i)) begin
                        stack_id_q[i]   <= win;
                        stack_addr_q[i] <= ret_addr_in;
                    end
                end
            end
            if (pop) begin
                ret_addr_q <= pop_addr;
                depth_q    <= depth_q - DW'(1);
            end
            if (err_set) stack_err_q <= 1'b1;
        end
    end

    // Output decode: the pulses are pure functions of the FSM state.
    always_comb begin
        vec_valid    = (state_q == S_VECTOR);
        ret_valid    = (state_q == S_RETURN);
        int_req      = int_req_q;
        vec_addr     = vec_addr_q;
        ret_addr_out = ret_addr_q;
        pending      = pending_q;
        depth_cnt    = depth_q;
        stack_err    = stack_err_q;
    end

endmodule

// File: tb/tb_irq_nest_controller.sv
// tb_irq_nest_controller
// Directed scenarios followed by a randomized phase, all checked against a
// transaction-level model: a pending set, a mask, a stack of (channel,
// return address) pairs and a sticky error flag.
module tb_irq_nest_controller;

    localparam int          NUM_IRQ  = 8;
    localparam int          AW       = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] VEC_BASE = 16'h0010;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_IRQ-1:0]   irq;
    logic                 int_enable;
    logic                 mask_we;
    logic [NUM_IRQ-1:0]   mask_wdata;
    logic                 int_req;
    logic                 int_ack;
    logic [AW-1:0]        ret_addr_in;
    logic                 vec_valid;
    logic [AW-1:0]        vec_addr;
    logic                 rti;
    logic                 ret_valid;
    logic [AW-1:0]        ret_addr_out;
    logic [NUM_IRQ-1:0]   pending;
    logic [2:0]           depth_cnt;
    logic                 stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [NUM_IRQ-1:0] m_pending;
    logic [NUM_IRQ-1:0] m_mask;
    logic               m_en;
    logic               m_err;
    int                 m_id[$];
    logic [AW-1:0]      exp_q[$];

    // Clock and timeout.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    irq_nest_controller #(
        .NUM_IRQ(NUM_IRQ), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .VEC_BASE(VEC_BASE)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .int_enable(int_enable),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .int_req(int_req),
        .int_ack(int_ack), .ret_addr_in(ret_addr_in), .vec_valid(vec_valid),
        .vec_addr(vec_addr), .rti(rti), .ret_valid(ret_valid),
        .ret_addr_out(ret_addr_out), .pending(pending), .depth_cnt(depth_cnt),
        .stack_err(stack_err)
    );

    // Model: highest-priority eligible channel, or -1.
    function automatic int m_win();
        int lim;
        lim = (m_id.size() == 0) ? NUM_IRQ : m_id[$];
        for (int k = 0; k < lim; k++) begin
            if (m_pending[k] && !m_mask[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic m_req();
        return m_en && (m_win() >= 0) && (m_id.size() < DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq = '0; int_ack = 1'b0; rti = 1'b0; mask_we = 1'b0;
        mask_wdata = '0; ret_addr_in = '0;
        tick(); tick();
        rst = 1'b0;
        m_pending = '0; m_mask = '0; m_err = 1'b0;
        m_id.delete(); exp_q.delete();
    endtask

    task automatic check_model(input string tag);
        settle();
        chk({tag, ".int_req"}, 32'(int_req), 32'(m_req()));
        chk({tag, ".pending"}, 32'(pending), 32'(m_pending));
        chk({tag, ".depth"}, 32'(depth_cnt), 32'(m_id.size()));
        chk({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
    endtask

    task automatic raise(input logic [NUM_IRQ-1:0] v);
        irq = v; tick();
        irq = '0; tick();
        m_pending = m_pending | v;
    endtask

    task automatic set_mask(input logic [NUM_IRQ-1:0] v);
        mask_we = 1'b1; mask_wdata = v; tick();
        mask_we = 1'b0;
        m_mask = v;
    endtask

    // Ack with an optional re-rise on some channels in the same cycle.
    task automatic do_ack(input logic [AW-1:0] addr, input logic [NUM_IRQ-1:0] rise_v);
        int   w;
        logic ok;
        w  = m_win();
        ok = m_req();
        int_ack = 1'b1; ret_addr_in = addr; irq = rise_v;
        tick();
        int_ack = 1'b0; irq = '0;
        chk("ack.vec_valid", 32'(vec_valid), 32'(ok));
        if (ok) begin
            chk("ack.vec_addr", 32'(vec_addr), 32'(VEC_BASE + AW'(w)));
            m_pending[w] = 1'b0;
            m_id.push_back(w);
            exp_q.push_back(addr);
        end
        m_pending = m_pending | rise_v;
        chk("ack.depth", 32'(depth_cnt), 32'(m_id.size()));
        tick();
        chk("ack.vec_pulse_end", 32'(vec_valid), 32'd0);
    endtask

    task automatic do_rti();
        logic [AW-1:0] exp_a;
        rti = 1'b1; tick(); rti = 1'b0;
        if (m_id.size() > 0) begin
            exp_a = exp_q.pop_back();
            void'(m_id.pop_back());
            chk("rti.ret_valid", 32'(ret_valid), 32'd1);
            chk("rti.ret_addr", 32'(ret_addr_out), 32'(exp_a));
        end else begin
            m_err = 1'b1;
            chk("rti.no_ret_valid", 32'(ret_valid), 32'd0);
        end
        chk("rti.depth", 32'(depth_cnt), 32'(m_id.size()));
        chk("rti.stack_err", 32'(stack_err), 32'(m_err));
        tick();
        chk("rti.ret_pulse_end", 32'(ret_valid), 32'd0);
    endtask

    initial begin
        int_enable = 1'b0; m_en = 1'b0;

        // Reset then idle.
        do_reset();
        chk("rst.int_req", 32'(int_req), 32'd0);
        chk("rst.vec_valid", 32'(vec_valid), 32'd0);
        chk("rst.ret_valid", 32'(ret_valid), 32'd0);
        chk("rst.vec_addr", 32'(vec_addr), 32'd0);
        chk("rst.ret_addr", 32'(ret_addr_out), 32'd0);
        chk("rst.pending", 32'(pending), 32'd0);
        chk("rst.depth", 32'(depth_cnt), 32'd0);
        chk("rst.stack_err", 32'(stack_err), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle.int_req", 32'(int_req), 32'd0);
        end

        // Single IRQ on channel 3 with exact request latency.
        int_enable = 1'b1; m_en = 1'b1;
        irq = 8'h08; tick();
        chk("lat.int_req_early", 32'(int_req), 32'd0);
        chk("lat.pending", 32'(pending), 32'h08);
        irq = '0; tick();
        chk("lat.int_req", 32'(int_req), 32'd1);
        m_pending = 8'h08;
        do_ack(16'h0123, '0);
        chk("single.vec_addr_13", 32'(vec_addr), 32'h0013);
        check_model("single.after_ack");
        do_rti();
        chk("single.ret_addr_123", 32'(ret_addr_out), 32'h0123);
        check_model("single.after_rti");

        // Priority, mask and pre-emption.
        set_mask(8'b0000_0100);
        raise(8'b0010_0100);
        check_model("prio.req");
        do_ack(16'h0200, '0);
        chk("prio.vec_15", 32'(vec_addr), 32'h0015);
        set_mask(8'h00);
        check_model("prio.preempt_req");
        do_ack(16'h0201, '0);
        chk("prio.vec_12", 32'(vec_addr), 32'h0012);
        chk("prio.depth2", 32'(depth_cnt), 32'd2);
        raise(8'b0100_0000);
        check_model("prio.ch6_blocked");
        chk("prio.ch6_no_req", 32'(int_req), 32'd0);
        do_reset();

        // Nesting limit: 7, 5, 3, 1 then channel 0 must wait.
        raise(8'h80); check_model("nest.r7"); do_ack(16'h1007, '0);
        raise(8'h20); check_model("nest.r5"); do_ack(16'h1005, '0);
        raise(8'h08); check_model("nest.r3"); do_ack(16'h1003, '0);
        raise(8'h02); check_model("nest.r1"); do_ack(16'h1001, '0);
        raise(8'h01);
        check_model("nest.full");
        chk("nest.full_no_req", 32'(int_req), 32'd0);
        chk("nest.depth4", 32'(depth_cnt), 32'd4);
        do_rti(); chk("nest.pop1", 32'(ret_addr_out), 32'h1001);
        do_rti(); chk("nest.pop3", 32'(ret_addr_out), 32'h1003);
        do_rti(); chk("nest.pop5", 32'(ret_addr_out), 32'h1005);
        do_rti(); chk("nest.pop7", 32'(ret_addr_out), 32'h1007);
        check_model("nest.unwound");
        do_reset();

        // Errors: rti at depth 0, then ack+rti together.
        do_rti();
        chk("err.underflow", 32'(stack_err), 32'd1);
        do_reset();
        chk("err.cleared_by_rst", 32'(stack_err), 32'd0);
        raise(8'h04);
        check_model("err.req");
        int_ack = 1'b1; rti = 1'b1; ret_addr_in = 16'h0300;
        tick();
        int_ack = 1'b0; rti = 1'b0;
        chk("both.vec_valid", 32'(vec_valid), 32'd1);
        chk("both.vec_addr", 32'(vec_addr), 32'h0012);
        chk("both.depth", 32'(depth_cnt), 32'd1);
        chk("both.stack_err", 32'(stack_err), 32'd1);
        chk("both.no_ret", 32'(ret_valid), 32'd0);
        m_pending = '0; m_err = 1'b1; m_id.push_back(2); exp_q.push_back(16'h0300);
        check_model("both.after");
        do_reset();

        // Set wins: channel 4 re-rises in its own ack cycle.
        raise(8'h10);
        check_model("setwin.req");
        do_ack(16'h0400, 8'h10);
        check_model("setwin.after");
        chk("setwin.pending4", 32'(pending[4]), 32'd1);

        // Reset during VECTOR drops the pulse and the stack.
        do_rti();
        check_model("rstvec.req");
        int_ack = 1'b1; ret_addr_in = 16'h0500; tick(); int_ack = 1'b0;
        chk("rstvec.vec_valid", 32'(vec_valid), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstvec.vec_dropped", 32'(vec_valid), 32'd0);
        chk("rstvec.depth", 32'(depth_cnt), 32'd0);
        chk("rstvec.pending", 32'(pending), 32'd0);
        m_pending = '0; m_mask = '0; m_err = 1'b0; m_id.delete(); exp_q.delete();
        check_model("rstvec.after");

        // Randomized operations against the model.
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 6))
                0, 1: raise(8'(1 << $urandom_range(0, NUM_IRQ - 1)));
                2: set_mask(8'($urandom) & 8'($urandom) & 8'($urandom));
                3, 4: do_ack(16'($urandom), '0);
                5: if (m_id.size() > 0 || $urandom_range(0, 9) == 0) do_rti();
                default: begin
                    int_enable = ($urandom_range(0, 3) != 0);
                    m_en = int_enable;
                end
            endcase
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
